// File: rtl/viterbi_pkg.sv
// Shared constants, FSM states and reference encode step for the
// convolutional encoder / Viterbi decoder pair.
package viterbi_pkg;

    localparam int K_DEF = 4;
    localparam logic [K_DEF-1:0] G0_DEF = 4'b1111;
    localparam logic [K_DEF-1:0] G1_DEF = 4'b1101;
    localparam int M_DEF = K_DEF - 1;
    localparam int S_DEF = 2 ** M_DEF;
    localparam int SYM_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_FLUSH
    } enc_state_e;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [M_DEF-1:0] st;
    } enc_step_t;

    // One trellis step: newest bit enters at the LSB of the state.
    function automatic enc_step_t encode(
        input logic [M_DEF-1:0] st,
        input logic             b
    );
        logic [K_DEF-1:0] r;
        enc_step_t        res;
        r       = {st, b};
        res.sym = {^(r & G0_DEF), ^(r & G1_DEF)};
        res.st  = {st[M_DEF-2:0], b};
        return res;
    endfunction

endpackage

// File: rtl/conv_encoder_framer_core.sv
// Combinational rate-1/2 encoder step: symbol and next shift-register
// state for the current state and input bit.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic [K-2:0]     st,
    input  logic             b,
    output logic [SYM_W-1:0] sym,
    output logic [K-2:0]     st_nxt
);

    logic [K-1:0] r;

    assign r      = {st, b};
    assign sym    = {^(r & G0), ^(r & G1)};
    assign st_nxt = {st[K-3:0], b};

endmodule

// File: rtl/conv_encoder_framer.sv
// Frame-based rate-1/2 convolutional encoder with optional zero tail,
// single-stage output register and valid/ready streams on both sides.
module conv_encoder_framer
    import viterbi_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF,
    parameter int TAIL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       frame_len,
    output logic             busy,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_last,
    output logic             done,
    output logic [8:0]       sym_count
);

    localparam int M = K - 1;
    localparam logic [8:0] TAIL_LEN = (TAIL != 0) ? 9'(M) : 9'd0;

    enc_state_e state, state_nxt;

    logic [M-1:0]     st;
    logic [M-1:0]     st_nxt;
    logic [7:0]       len_q;
    logic [SYM_W-1:0] sym_nxt;
    logic [8:0]       cnt_inc;
    logic [8:0]       total;
    logic             adv;
    logic             enc_b;
    logic             step;
    logic             start_ok;

    assign adv       = !sym_valid || sym_ready;
    assign bit_ready = (state == ST_DATA) && adv;
    assign enc_b     = (state == ST_DATA) && bit_in;
    assign step      = (bit_ready && bit_valid)
                     || ((state == ST_TAIL) && adv);
    assign cnt_inc   = sym_count + 9'd1;
    assign total     = {1'b0, len_q} + TAIL_LEN;
    assign start_ok  = (state == ST_IDLE) && start;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .st     (st),
        .b      (enc_b),
        .sym    (sym_nxt),
        .st_nxt (st_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len != 8'd0) begin
                        state_nxt = ST_DATA;
                    end else if (TAIL != 0) begin
                        state_nxt = ST_TAIL;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_DATA: begin
                if (step && (cnt_inc == {1'b0, len_q})) begin
                    state_nxt = (TAIL != 0) ? ST_TAIL : ST_FLUSH;
                end
            end
            ST_TAIL: begin
                if (step && (cnt_inc == total)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (adv) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output register, counters and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '0;
            len_q     <= '0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
            sym_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                len_q     <= frame_len;
                st        <= '0;
                sym_count <= '0;
                busy      <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (step) begin
                st        <= st_nxt;
                sym_out   <= sym_nxt;
                sym_valid <= 1'b1;
                sym_last  <= (cnt_inc == total);
                sym_count <= cnt_inc;
            end else if (sym_ready) begin
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end
            if ((state == ST_FLUSH) && adv) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Frame-based rate-1/2 convolutional encoder. Sits directly upstream of the Viterbi decoder and produces the 2-bit symbol stream the decoder consumes.
- Accepts a frame of data bits over a valid/ready stream. Optionally appends M = K-1 zero tail bits so the trellis terminates in state 0.
- Emits one symbol per encoded bit over a valid/ready stream, with a last-symbol flag and a done pulse.

Parameters:
- K, 4, constraint length (3..9)
- G0, 4'b1111, generator polynomial for symbol bit 1, K bits
- G1, 4'b1101, generator polynomial for symbol bit 0, K bits
- TAIL, 1, 1 = append M zero tail bits after the data; 0 = no tail

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches frame_len and begins a frame (honoured only in IDLE)
- frame_len  in  8  number of data bits in the frame (0..255)
- busy  out  1  high from the accepted start until the done pulse, inclusive
- bit_in  in  1  data bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  encoder accepts bit_in this cycle
- sym_out  out  2  {parity(r&G0), parity(r&G1)}, with r = {state, bit}
- sym_valid  out  1  sym_out is valid
- sym_ready  in  1  downstream accepts sym_out
- sym_last  out  1  high with the final symbol of the frame
- done  out  1  one-cycle pulse after the final symbol handshakes
- sym_count  out  9  symbols emitted in the current/last frame; reaches frame_len + (TAIL ? M : 0)

Behaviour:
- M = K-1. Encoder shift register st[M-1:0].
  - Per encoded bit b: r = {st, b}; sym = {^(r&G0), ^(r&G1)}; st <= {st[M-2:0], b} (LSB insertion).
- Reset (async, rst_n=0), all outputs and registers cleared:
  - st=0, FSM=IDLE, sym_valid=0, sym_out=0, sym_last=0, done=0, busy=0, sym_count=0, bit_ready=0.
  - Reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, DATA, TAIL, FLUSH.
  - IDLE: on start, latch frame_len, clear st and sym_count, set busy. Next state:
    - DATA if frame_len>0;
    - TAIL if frame_len=0 and TAIL=1;
    - FLUSH otherwise (done pulses the following cycle, sym_count=0, no symbols emitted).
  - DATA: advance on each accepted bit. After frame_len bits, go to TAIL if TAIL=1, else FLUSH.
  - TAIL: internally generates b=0, M times, with no input handshake, then goes to FLUSH.
  - FLUSH: waits for the output register to drain (sym_valid=0 or last handshake). Then pulses done for one cycle, clears busy, returns to IDLE.
- Output register rule: one stage, so symbol latency is 1 cycle from bit acceptance.
  - Let adv = (!sym_valid || sym_ready).
  - bit_ready = (state==DATA) && adv.
  - A bit is accepted when bit_valid && bit_ready. In TAIL, a tail bit advances whenever adv.
  - On advance, sym_out/sym_valid are loaded and sym_count increments. Otherwise sym_valid clears on handshake.
  - Full throughput: one symbol per cycle when sym_ready stays high.
- sym_out must hold stable while sym_valid && !sym_ready.
- sym_last is asserted with the symbol whose count equals the total (frame_len + TAIL*M). It is never asserted for a total of 0.
- start outside IDLE is ignored, and frame_len is not re-latched.
- With TAIL=1, st=0 at done.
- sym_count holds its value after done until the next accepted start.

Decomposition:
- Shared package viterbi_pkg holds:
  - default K, G0, G1;
  - M = K-1 and S = 2**M as derived constants;
  - the symbol width (2);
  - an encode function taking (st, b) and returning {sym, next_st}.
- The decoder bench's reference encoder reuses the same function.
- One natural sub-module: conv_enc_core (combinational symbol/next-state compute, parameterised by K, G0, G1). The FSM, counters and output register stay in the top.

Test Plan:
- K=4, TAIL=0, frame_len=32, impulse at bit 12, sym_ready=1 → 32 symbols. Symbols 12..15 are 3,2,3,3, all others 0. sym_last on symbol 31, done one cycle after it, sym_count=32.
- TAIL=1, frame_len=1, bit=1 → symbols 3,2,3,3, sym_last on the 4th, sym_count=4, st=0 at done.
- Backpressure: frame_len=8, alternating 1/0 bits, sym_ready toggled pseudo-randomly → sym_out stable while stalled. The symbol sequence is identical to the sym_ready=1 run, with no drops or duplicates.
- frame_len=0: with TAIL=0, done pulses with sym_count=0 and no sym_valid. With TAIL=1, 3 zero symbols are emitted, with sym_last on the 3rd.
- Async reset mid-frame (rst_n low after 5 of 20 bits) → all outputs 0 immediately, no done pulse. A new start afterwards encodes correctly from st=0.
- start pulsed while busy → ignored, frame length unchanged. Feeding the output frame to viterbi_simple_v2 reproduces the input bits exactly.
